// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - operand fetch, issue and writeback controller for the 32-bit ALU
module alu_issue_ctrl #(
    parameter int NREGS = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [2:0]      cmd_rd,
    input  logic [2:0]      cmd_rs1,
    input  logic [2:0]      cmd_rs2,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_zero,
    output logic [2:0]      rsp_rd,
    input  logic            host_we,
    input  logic [2:0]      host_addr,
    input  logic [XLEN-1:0] host_wdata,
    input  logic [2:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] regs [NREGS];
    logic [2:0]      rd;
    logic            accept;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_data  = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand reads use pre-edge contents; a same-cycle host write is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            rd       <= '0;
        end else if (accept) begin
            alu_a    <= (cmd_rs1 == 3'd0) ? '0 : regs[cmd_rs1];
            alu_b    <= (cmd_rs2 == 3'd0) ? '0 : regs[cmd_rs2];
            alu_ctrl <= cmd_op;
            rd       <= cmd_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_rd   <= '0;
        end else if (state == EXEC) begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_rd   <= rd;
        end
    end

    // Writeback is assigned last so it wins a same-address collision with the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_we && host_addr != 3'd0) begin
                regs[host_addr] <= host_wdata;
            end
            if (state == EXEC && rd != 3'd0) begin
                regs[rd] <= alu_result;
            end
        end
    end

endmodule
